imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Writer side of the instruction memory. Receives a byte stream (from the UART receiver or debug port) and assembles big-endian 32-bit instruction words. Writes them sequentially into the instruction memory write port starting at word 0, which replaces hard-coded ROM images with runtime program loading. Holds the CPU in reset while a load is in progress.

Parameters:
ADDR_W, 9, instruction memory word-address width.
MEM_SIZE, 512, instruction memory depth in words; maximum legal load length.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  single-cycle pulse that begins a load; honoured in IDLE or DONE only.
rx_data  input  8  received byte.
rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
wr_en  output  1  instruction memory write enable, one-cycle pulse per word.
wr_addr  output  ADDR_W  word address of the write.
wr_data  output  32  instruction word to write.
busy  output  1  load in progress.
cpu_hold  output  1  CPU reset request; equals busy.
done  output  1  load finished; stays high until the next start or reset.
err  output  1  load failed; valid when done=1.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, cpu_hold=0, done=0, err=0.
  - Internal byte index, word index and length register are cleared.
  - Reset mid-load abandons the load immediately. Words already written remain in memory.
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM (only with the feature), FINISH, DONE.
- IDLE/DONE:
  - rx_valid is ignored.
  - On start: clear done and err, set busy=1, clear word index and byte index, go to LEN_HI.
- start while busy is ignored.
- LEN_HI: on rx_valid, len[15:8]<=rx_data; go to LEN_LO.
- LEN_LO: on rx_valid, len[7:0]<=rx_data.
  - If the resulting length is 0 or greater than MEM_SIZE: err<=1, go to FINISH.
  - Otherwise go to DATA.
- DATA:
  - Each rx_valid shifts the byte in: word <= {word[23:0], rx_data}. The first byte of a word is its MSB.
  - Byte index counts 0..3 and wraps.
  - On the edge that accepts byte 3: wr_en<=1, wr_data<={word[23:0], rx_data}, wr_addr<=word index.
  - On the following cycle wr_en returns to 0 and the word index increments.
  - After the word at index len-1 is written, go to FINISH (or to CSUM with the feature).
- Bytes may arrive back-to-back (rx_valid every cycle) or with arbitrary gaps. No byte is dropped.
- wr_en is never high two consecutive cycles; the minimum spacing is 4 cycles.
- FINISH: lasts one cycle, then go to DONE with done<=1 and busy<=0. The final wr_en has therefore always deasserted before busy falls.
- The word index never exceeds MEM_SIZE-1, so wr_addr never wraps.
- If rx_valid and start arrive in the same IDLE cycle, start wins and the byte is discarded.

Optional Feature:
Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all data bytes (length bytes excluded) is kept, cleared on start.
  - After the last word, the CSUM state accepts one byte.
  - If the byte differs from the running XOR, err<=1. Either way, go to FINISH.
  - Words are written regardless of the checksum result.
- Not defined: no CSUM state. Go directly DATA->FINISH. err is set only by an illegal length.

Test Plan:
1. Reset, start, bytes 00 02 20 04 00 00 8c 90 00 00 back-to-back -> wr_en pulses with addr0=0x20040000 and addr1=0x8c900000; done=1, err=0, busy=0 one cycle after FINISH. With checksum: extra byte 0x38 gives err=0.
2. start, bytes 00 00 -> no wr_en, done=1, err=1. Then start, bytes 02 01 (513) -> err=1, no writes.
3. Load of 1 word with 3 idle cycles between bytes, plus a start pulse mid-load -> single write, addr0=0x8c910004; the mid-load start is ignored.
4. rst_n low for one cycle after 5 data bytes -> all outputs 0 next cycle. A new start followed by 00 01 11 22 33 44 -> write addr0=0x11223344.
5. Checksum enabled, data 20 04 00 00 8c 90 00 00 with checksum byte 0x39 -> both words written, done=1, err=1.
6. Load of MEM_SIZE words (len 0x0200) -> last wr_addr=511, exactly 512 wr_en pulses, err=0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 32-bit words written sequentially from word 0.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module imem_loader #(
  parameter int ADDR_W   = 9,
  parameter int MEM_SIZE = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM,
`endif
    FINISH, DONE
  } state_t;
  state_t            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [23:0]       word_q, word_d;
  logic [1:0]        byte_q, byte_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [15:0]       new_len;
  logic              last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif
  assign new_len   = {len_hi_q, rx_data};
  // Word index is compared before its post-write increment, so it never reaches MEM_SIZE.
  assign last_word = {1'b0, widx_q} == len_q - (ADDR_W+1)'(1);
  always_comb begin
    state_d   = state_q;
    len_hi_d  = len_hi_q;
    len_d     = len_q;
    word_d    = word_q;
    byte_d    = byte_q;
    widx_d    = widx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      IDLE, DONE: if (start) begin
        done_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = 1'b1;
        widx_d  = '0;
        byte_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = '0;
`endif
        state_d = LEN_HI;
      end
      LEN_HI: if (rx_valid) begin
        len_hi_d = rx_data;
        state_d  = LEN_LO;
      end
      LEN_LO: if (rx_valid) begin
        len_d = new_len[ADDR_W:0];
        if (new_len == 16'd0 || new_len > 16'(MEM_SIZE)) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else state_d = DATA;
      end
      DATA: begin
        if (wr_en_q) widx_d = widx_q + ADDR_W'(1);
        if (rx_valid) begin
          word_d = {word_q[15:0], rx_data};
          byte_d = byte_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (byte_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_data_d = {word_q, rx_data};
            wr_addr_d = widx_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (last_word) state_d = CSUM;
`else
            if (last_word) state_d = FINISH;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: if (rx_valid) begin
        if (rx_data != csum_q) err_d = 1'b1;
        state_d = FINISH;
      end
`endif
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_hi_q  <= '0;
      len_q     <= '0;
      word_q    <= '0;
      byte_q    <= '0;
      widx_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_hi_q  <= len_hi_d;
      len_q     <= len_d;
      word_q    <= word_d;
      byte_q    <= byte_d;
      widx_q    <= widx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign cpu_hold = busy_q;
  assign done     = done_q;
  assign err      = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader (default and checksum builds).
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy, cpu_hold, done, err;
  int          checks = 0;
  int          passes = 0;
  int          wr_cnt = 0;
  int          consec = 0;
  int          base;
  logic        prev_wr = 1'b0;
  logic [8:0]  last_addr = '0;
  logic [31:0] mem [512];

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    prev_wr <= wr_en;
    if (wr_en && prev_wr) consec <= consec + 1;
    if (wr_en) begin
      wr_cnt         <= wr_cnt + 1;
      last_addr      <= wr_addr;
      mem[wr_addr]   <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) send(w[i*8 +: 8], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  initial begin
    // Test 1: reset, then two-word back-to-back load
    repeat (2) @(negedge clk);
    check("reset_outs", {wr_en, wr_addr, wr_data, busy, cpu_hold, done, err}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    base = wr_cnt;
    pulse_start();
    check("t1_busy", {busy, cpu_hold, done, err}, 64'b1100);
    send(8'h00, 0);
    send(8'h02, 0);
    send_word(32'h20040000, 0);
    send_word(32'h8c900000, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h38, 0);
    wait_done("t1");
`else
    check("t1_last_wr", {wr_en, wr_addr, wr_data, busy, done}, {1'b1, 9'd1, 32'h8c900000, 1'b1, 1'b0});
    @(negedge clk);
    check("t1_finish", {wr_en, busy, done}, 64'b001);
`endif
    check("t1_status", {busy, cpu_hold, done, err}, 64'b0010);
    check("t1_count", 64'(wr_cnt - base), 64'd2);
    check("t1_w0", 64'(mem[0]), 64'h20040000);
    check("t1_w1", 64'(mem[1]), 64'h8c900000);
    // Test 2: illegal lengths 0 and 513
    base = wr_cnt;
    pulse_start();
    check("t2_clear", {busy, done, err}, 64'b100);
    send(8'h00, 0);
    send(8'h00, 0);
    wait_done("t2a");
    check("t2a_err", {busy, err}, 64'b01);
    pulse_start();
    send(8'h02, 0);
    send(8'h01, 0);
    wait_done("t2b");
    check("t2b_err", {busy, err}, 64'b01);
    check("t2_nowrites", 64'(wr_cnt - base), 64'd0);
    // Test 3: one word with 3-cycle gaps and an ignored mid-load start
    base = wr_cnt;
    pulse_start();
    send(8'h00, 3);
    send(8'h01, 3);
    send(8'h8c, 3);
    pulse_start();
    check("t3_still_busy", {busy, done}, 64'b10);
    send(8'h91, 3);
    send(8'h00, 3);
    send(8'h04, 3);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h19, 0);
`endif
    wait_done("t3");
    check("t3_count", 64'(wr_cnt - base), 64'd1);
    check("t3_w0", {last_addr, mem[0]}, {9'd0, 32'h8c910004});
    check("t3_err", 64'(err), 64'd0);
    // Test 4: reset mid-load, then a fresh one-word load
    pulse_start();
    send(8'h00, 0);
    send(8'h02, 0);
    send_word(32'h01020304, 0);
    send(8'h05, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t4_reset_outs", {wr_en, wr_addr, wr_data, busy, cpu_hold, done, err}, 64'd0);
    check("t4_kept", 64'(mem[0]), 64'h01020304);
    rst_n = 1'b1;
    base = wr_cnt;
    pulse_start();
    send(8'h00, 0);
    send(8'h01, 0);
    send_word(32'h11223344, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h44, 0);
`endif
    wait_done("t4");
    check("t4_count", 64'(wr_cnt - base), 64'd1);
    check("t4_w0", 64'(mem[0]), 64'h11223344);
    check("t4_err", 64'(err), 64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    // Test 5: bad checksum still writes both words
    base = wr_cnt;
    pulse_start();
    send(8'h00, 0);
    send(8'h02, 0);
    send_word(32'h20040000, 0);
    send_word(32'h8c900000, 0);
    send(8'h39, 0);
    wait_done("t5");
    check("t5_err", 64'(err), 64'd1);
    check("t5_count", 64'(wr_cnt - base), 64'd2);
`endif
    // Test 6: full-depth load of 512 words
    base = wr_cnt;
    pulse_start();
    send(8'h02, 0);
    send(8'h00, 0);
    for (int i = 0; i < 512; i++) send_word({8'hA5, 8'(i >> 8), 8'(i), 8'h5A}, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h00, 0);
`endif
    wait_done("t6");
    check("t6_count", 64'(wr_cnt - base), 64'd512);
    check("t6_last_addr", 64'(last_addr), 64'd511);
    check("t6_w511", 64'(mem[511]), 64'hA501FF5A);
    check("t6_w300", 64'(mem[300]), 64'hA5012C5A);
    check("t6_err", {busy, err}, 64'b00);
    check("no_consec_wr", 64'(consec), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
